// File: rtl/dm_ctrl_pkg.sv
// Shared encodings for the data-memory byte controller: op codes, FSM states, lane sizes.
package dm_ctrl_pkg;

    localparam logic [2:0] OP_LW = 3'b000;
    localparam logic [2:0] OP_SW = 3'b001;
    localparam logic [2:0] OP_LB = 3'b010;
    localparam logic [2:0] OP_SB = 3'b011;
    localparam logic [2:0] OP_LH = 3'b100;
    localparam logic [2:0] OP_SH = 3'b101;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_DATA,
        ST_WR,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    function automatic size_t op_size(input logic [2:0] op);
        size_t sz;
        sz = SZ_WORD;
        case (op)
            OP_LB, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_SH: sz = SZ_HALF;
            default:      sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dm_lane_mux.sv
// Byte/half lane extraction with sign extension, and lane merge for read-modify-write.
// Purely combinational (0 cycles); no flow control.
// Little-endian lanes: byte lane 0 is bits [7:0], half lane 0 is bits [15:0].
module dm_lane_mux
    import dm_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] rdata,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        lane,
    input  size_t             size,
    output logic [WORD_W-1:0] extracted,
    output logic [WORD_W-1:0] merged
);

    logic [BYTE_W-1:0] rbyte;
    logic [HALF_W-1:0] rhalf;

    always_comb begin
        rbyte     = rdata[BYTE_W*lane +: BYTE_W];
        rhalf     = rdata[HALF_W*lane[1] +: HALF_W];
        extracted = rdata;
        merged    = wdata;
        case (size)
            SZ_BYTE: begin
                extracted = {{(WORD_W-BYTE_W){rbyte[BYTE_W-1]}}, rbyte};
                merged    = rdata;
                merged[BYTE_W*lane +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            SZ_HALF: begin
                extracted = {{(WORD_W-HALF_W){rhalf[HALF_W-1]}}, rhalf};
                merged    = rdata;
                merged[HALF_W*lane[1] +: HALF_W] = wdata[HALF_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_byte_ctrl.sv
// Sequences core LW/SW/LB/SB (LH/SH when DM_HALF_EN is defined) onto a word-wide sync-read memory.
// Latency accept->resp: error 1, SW 2, loads 3, SB/SH 4 cycles (SB/SH are read-modify-write).
// Backpressure: req_ready high only in IDLE; one request in flight, requests while busy are ignored.
module dm_byte_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    state_t              state;
    logic [2:0]          op_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                err_q;
    logic                req_bad;
    logic                is_store;
    logic [WORD_W-1:0]   lane_ext;
    logic [WORD_W-1:0]   lane_merged;
    logic                addr_unused;

    // Upper address bits wrap within the memory and are intentionally dropped.
    assign addr_unused = ^req_addr[31:ADDR_W+2];

    always_comb begin
        req_bad = 1'b0;
        case (req_op)
            OP_LW, OP_SW: req_bad = (req_addr[1:0] != 2'b00);
            OP_LB, OP_SB: req_bad = 1'b0;
`ifdef DM_HALF_EN
            OP_LH, OP_SH: req_bad = req_addr[0];
`endif
            default:      req_bad = 1'b1;
        endcase
    end

    assign is_store = (op_q == OP_SB) || (op_q == OP_SH);

    dm_lane_mux u_lane_mux (
        .rdata     (mem_rdata),
        .wdata     (wdata_q),
        .lane      (addr_q[1:0]),
        .size      (op_size(op_q)),
        .extracted (lane_ext),
        .merged    (lane_merged)
    );

    // Strobes decode from the state register alone so reset drops them immediately.
    assign req_ready  = (state == ST_IDLE);
    assign mem_re     = (state == ST_RD);
    assign mem_we     = (state == ST_WR);
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = resp_valid & err_q;
    assign mem_addr   = addr_q[ADDR_W+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            resp_rdata <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr[ADDR_W+1:0];
                        wdata_q <= req_wdata;
                        err_q   <= req_bad;
                        if (req_bad) begin
                            state <= ST_RESP;
                        end else if (req_op == OP_SW) begin
                            mem_wdata <= req_wdata;
                            state     <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: state <= ST_DATA;
                ST_DATA: begin
                    if (is_store) begin
                        mem_wdata <= lane_merged;
                        state     <= ST_WR;
                    end else begin
                        resp_rdata <= lane_ext;
                        state      <= ST_RESP;
                    end
                end
                ST_WR:   state <= ST_RESP;
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dm_byte_ctrl.md
Name: dm_byte_ctrl

Overview:
Sequencing controller between the MIPS core's memory stage and a word-wide synchronous-read data memory. It serves LW/SW directly and implements LB through byte extraction with sign extension. It implements SB as a read-modify-write, because the memory has no byte enables. It exposes a valid/ready request port and a one-cycle response pulse to the core.

Parameters:
ADDR_W, 10, word-address width of data memory (2^ADDR_W words)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  core presents a request
req_ready  output  1  controller accepts a request this cycle (high only in IDLE)
req_op  input  3  000 LW, 001 SW, 010 LB, 011 SB, 100 LH, 101 SH, others reserved
req_addr  input  32  byte address
req_wdata  input  32  store data (SB uses [7:0], SH uses [15:0])
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result, held until the next response
resp_err  output  1  qualifies resp_valid: misaligned or unsupported op
mem_addr  output  ADDR_W  word address = latched req_addr[ADDR_W+1:2]
mem_re  output  1  read strobe; mem_rdata is valid the following cycle
mem_rdata  input  32  memory read data
mem_we  output  1  full-word write strobe
mem_wdata  output  32  write data

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - req_ready = 1.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - mem_re = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- States: IDLE, RD, DATA, WR, RESP. Memory strobes decode from state only, so async reset kills an in-flight strobe immediately.
- IDLE:
  - On req_valid and req_ready, latch op, addr and wdata.
  - Next state:
    - RESP with err=1: misaligned LW/SW (addr[1:0]≠0), misaligned LH/SH (addr[0]≠0), or a reserved op.
    - WR: SW.
    - RD: all other ops.
- RD: mem_re=1 → DATA.
- DATA: mem_rdata valid.
  - Loads: register the extracted result into resp_rdata → RESP.
    - LW: the whole word.
    - LB: sign-extend byte lane addr[1:0]. Lane 0 is bits [7:0] (little-endian).
    - LH: sign-extend half lane addr[1].
  - SB/SH: merge the store byte/half into the read word, register it as mem_wdata → WR.
- WR: mem_we=1, mem_wdata = store word (SW) or merged word → RESP.
- RESP: resp_valid=1. resp_err is set per the request, and resp_rdata is unchanged on error or store → IDLE.
- Latency from the accept cycle (C0) to resp_valid:
  - LW/LB/LH: C3.
  - SW: C2.
  - SB/SH: C4.
  - Error: C1.
- req_valid while busy is ignored. The core must hold its request until req_ready is high; no queueing.
- Address bits above ADDR_W+1 are ignored (wrap-around within memory).
- A reset mid-operation aborts it: no write occurs if reset is asserted before the WR cycle, and no response is produced.

Optional Feature:
DM_HALF_EN
- Defined: LH/SH are served as above.
- Undefined: ops 100/101 are treated as reserved → error response at C1, with no memory access.

Decomposition:
- Package dm_ctrl_pkg holds:
  - op encodings (OP_LW..OP_SH);
  - the state enum;
  - lane-width constants.
- Sub-module dm_lane_mux, purely combinational:
  - extract: rdata, addr[1:0], size → sign-extended value;
  - merge: rdata, wdata, addr[1:0], size → merged word.
- Both load and RMW paths reuse dm_lane_mux.

Test Plan:
- SW addr 0x4 data 0x87654321 → mem_we pulse at C1 with mem_addr=1 and mem_wdata=0x87654321. resp_valid at C2, err=0.
- LB addr 0x7 (after the test above) → mem_re at C1, resp_rdata=0xFFFFFF87 at C3. LB addr 0x4 → 0x00000021.
- SB addr 0x6 wdata 0x000000AB → RD C1, WR C3 with mem_wdata=0x87AB4321, resp at C4. A following LW addr 0x4 returns 0x87AB4321.
- LW addr 0x2 → resp_valid with err=1 at C1. No mem_re/mem_we asserted; req_ready high again at C2.
- SB in progress, reset asserted during DATA:
  - mem_we never asserts and resp_valid stays 0.
  - Word 1 is unchanged, confirmed by a later LW.
  - All outputs are at reset values in the same cycle reset is asserted.
- With DM_HALF_EN: SH addr 0x4 wdata 0xBEEF → word 0x87ABBEEF, then LH addr 0x4 → 0xFFFFBEEF.
- Without DM_HALF_EN: LH addr 0x4 → err=1 at C1.
